dfg_operand_loader: RTL and testbench
=====================================

Name: dfg_operand_loader

Overview:
- Upstream/downstream I/O stage for the scheduled ALU datapath and its controller.
- Collects eight 32-bit operands from a valid/ready stream and holds them stable on i1..i8.
- Pulses start, waits for the datapath's done, then returns the captured result on a valid/ready output stream.
- Detects framing errors and datapath timeouts.

Parameters:
DATA_W, 32, operand/result width
TIMEOUT, 64, max cycles in WAIT before abort (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operand beat valid
in_data  in  DATA_W  operand beat
in_last  in  1  marks final beat of frame
in_ready  out  1  loader accepts beat
i1..i8  out  DATA_W each  held operands to datapath
start  out  1  one-cycle run request to controller
done  in  1  datapath done (registered, may stay high)
result_in  in  DATA_W  datapath result, valid while done high
out_valid  out  1  result available
out_data  out  DATA_W  captured result
out_ready  in  1  consumer accepts result
busy  out  1  state != LOAD
err_short  out  1  sticky: in_last before 8th beat
err_nolast  out  1  sticky: 8th beat without in_last
err_timeout  out  1  sticky: no done within TIMEOUT cycles
err_clr  in  1  clears all sticky errors

Behaviour:
- Reset (async): state=LOAD, beat cnt=0, i1..i8=0, start=0, out_valid=0, out_data=0, all err=0, wait counter=0.
- in_ready = (state==LOAD) && !rst. Combinational from registered state only, with no dependency on in_valid.
- States: LOAD, WAIT, OUT.
- LOAD:
  - Beat accepted when in_valid && in_ready. Writes in_data into i[cnt+1]; cnt increments (3-bit).
  - in_last on an accepted beat with cnt<7:
    - err_short <= 1; cnt <= 0; frame discarded.
    - i-registers keep the partially written values.
    - No start.
  - Accepted beat with cnt==7:
    - Writes i8; cnt <= 0; start <= 1; state <= WAIT; wait counter <= 1.
    - If in_last==0 on this beat, err_nolast <= 1, but the frame is still processed.
- WAIT:
  - start is high only in the first WAIT cycle, then 0.
  - done is ignored while start==1 (stale done from the previous run). The counter increments each cycle.
  - First cycle with done==1 && start==0: out_data <= result_in; out_valid <= 1; state <= OUT.
  - If the counter reaches TIMEOUT without qualifying done: err_timeout <= 1; state <= LOAD; no output produced.
  - done==1 and the counter reaching TIMEOUT in the same cycle: done wins.
- OUT:
  - out_valid and out_data held stable until out_ready.
  - On out_valid && out_ready: out_valid <= 0; state <= LOAD. in_ready rises the next cycle.
  - done is ignored in OUT and LOAD.
- i1..i8 change only on accepted beats in LOAD. They are stable for the whole WAIT and OUT period.
- Errors: sticky until err_clr. If a set and err_clr occur in the same cycle, the set wins.
- Latency:
  - Last beat accepted at cycle T → start high at T+1.
  - done first sampled high at cycle D → out_valid high at D+1.
  - Minimum in→out turnaround: 8 beats + 1 + datapath run + 1.
- Reset mid-operation (any state): immediately returns to the reset values.
  - An in-flight frame or result is lost.
  - start deasserts asynchronously.
- Widths: no arithmetic on data. out_data is captured verbatim from result_in (DATA_W bits, no extension).

Test Plan:
- Eight beats 1..8, in_last on beat 8, done raised 5 cycles after start with result_in=0x24 → i1..i8=1..8, start exactly one cycle, out_valid with out_data=0x24, no errors, busy low after handshake.
- Same frame, out_ready held low 10 cycles → out_valid/out_data stable 10 cycles; in_ready=0 throughout; single transfer when out_ready rises.
- in_last on beat 3 (values 0xA,0xB,0xC) → err_short=1, no start, in_ready stays 1. A following full 8-beat frame completes normally. err_clr then clears err_short.
- 8 beats with in_last=0 → err_nolast=1 and start still pulses. done held high from the previous run during the start cycle is not taken as completion; the new done is.
- done never asserted → err_timeout=1 exactly TIMEOUT(64) cycles after start, state back to LOAD, out_valid never asserts.
- rst asserted mid-WAIT and again while OUT holds 0xDEADBEEF → all outputs 0 immediately, in_ready=0 during rst and 1 after release; the next frame runs normally.

Source files
------------

// File: rtl/dfg_operand_loader.sv
// Operand loader / result returner around the scheduled ALU datapath:
// gathers an 8-beat operand frame, launches a run, and hands back the result.
module dfg_operand_loader #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] i1,
    output logic [DATA_W-1:0] i2,
    output logic [DATA_W-1:0] i3,
    output logic [DATA_W-1:0] i4,
    output logic [DATA_W-1:0] i5,
    output logic [DATA_W-1:0] i6,
    output logic [DATA_W-1:0] i7,
    output logic [DATA_W-1:0] i8,
    output logic              start,
    input  logic              done,
    input  logic [DATA_W-1:0] result_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              err_short,
    output logic              err_nolast,
    output logic              err_timeout,
    input  logic              err_clr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [DATA_W-1:0] ops_q [8];
    logic [DATA_W-1:0] ops_d [8];
    logic              start_q, start_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              err_short_q, err_short_d;
    logic              err_nolast_q, err_nolast_d;
    logic              err_timeout_q, err_timeout_d;
    logic              short_set_s, nolast_set_s, timeout_set_s;

    // Sticky error update: a new error in the same cycle as err_clr survives.
    function automatic logic sticky_next(input logic set_v, input logic clr_v, input logic cur_v);
        if (set_v) begin
            sticky_next = 1'b1;
        end else if (clr_v) begin
            sticky_next = 1'b0;
        end else begin
            sticky_next = cur_v;
        end
    endfunction

    // Next-state and datapath-register update for the LOAD/WAIT/OUT sequencer.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wait_d        = wait_q;
        start_d       = 1'b0;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        short_set_s   = 1'b0;
        nolast_set_s  = 1'b0;
        timeout_set_s = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ops_d[k] = ops_q[k];
        end

        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    ops_d[cnt_q] = in_data;
                    if (cnt_q == 3'd7) begin
                        cnt_d        = 3'd0;
                        start_d      = 1'b1;
                        state_d      = S_WAIT;
                        wait_d       = CNT_W'(1);
                        nolast_set_s = ~in_last;
                    end else if (in_last) begin
                        // Short frame: drop it, keep whatever operands were written.
                        cnt_d       = 3'd0;
                        short_set_s = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_WAIT: begin
                // A done seen during the start cycle belongs to the previous run.
                if (done && !start_q) begin
                    out_data_d  = result_in;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                    wait_d      = '0;
                end else if (wait_q == WAIT_MAX) begin
                    timeout_set_s = 1'b1;
                    state_d       = S_LOAD;
                    wait_d        = '0;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_LOAD;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        err_short_d   = sticky_next(short_set_s,   err_clr, err_short_q);
        err_nolast_d  = sticky_next(nolast_set_s,  err_clr, err_nolast_q);
        err_timeout_d = sticky_next(timeout_set_s, err_clr, err_timeout_q);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_LOAD;
            cnt_q         <= 3'd0;
            wait_q        <= '0;
            start_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            err_short_q   <= 1'b0;
            err_nolast_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                ops_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wait_q        <= wait_d;
            start_q       <= start_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            err_short_q   <= err_short_d;
            err_nolast_q  <= err_nolast_d;
            err_timeout_q <= err_timeout_d;
            for (int k = 0; k < 8; k++) begin
                ops_q[k] <= ops_d[k];
            end
        end
    end

    assign in_ready    = (state_q == S_LOAD) && !rst;
    assign busy        = (state_q != S_LOAD);
    assign start       = start_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign err_short   = err_short_q;
    assign err_nolast  = err_nolast_q;
    assign err_timeout = err_timeout_q;
    assign i1 = ops_q[0];
    assign i2 = ops_q[1];
    assign i3 = ops_q[2];
    assign i4 = ops_q[3];
    assign i5 = ops_q[4];
    assign i6 = ops_q[5];
    assign i7 = ops_q[6];
    assign i8 = ops_q[7];

endmodule

// File: tb/tb_dfg_operand_loader.sv
// Self-checking bench for dfg_operand_loader: directed scenarios plus random
// frames, compared against a frame-level model of operands, result and errors.
module tb_dfg_operand_loader;

    localparam int TO = 64;

    logic        clk, rst;
    logic        in_valid, in_last, in_ready;
    logic [31:0] in_data;
    logic [31:0] i1, i2, i3, i4, i5, i6, i7, i8;
    logic        start, done, out_valid, out_ready, busy;
    logic [31:0] result_in, out_data;
    logic        err_short, err_nolast, err_timeout, err_clr;
    logic [31:0] ops_o [8];

    int checks_cnt   = 0;
    int failures_cnt = 0;

    // Reference model state
    logic [31:0] exp_ops [8];
    logic        exp_short, exp_nolast, exp_timeout;

    dfg_operand_loader #(.DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .i6(i6), .i7(i7), .i8(i8),
        .start(start), .done(done), .result_in(result_in),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .err_short(err_short), .err_nolast(err_nolast),
        .err_timeout(err_timeout), .err_clr(err_clr)
    );

    assign ops_o[0] = i1; assign ops_o[1] = i2; assign ops_o[2] = i3; assign ops_o[3] = i4;
    assign ops_o[4] = i5; assign ops_o[5] = i6; assign ops_o[6] = i7; assign ops_o[7] = i8;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_errs(input string tag);
        check_val({tag, ".err_short"},   {31'd0, err_short},   {31'd0, exp_short});
        check_val({tag, ".err_nolast"},  {31'd0, err_nolast},  {31'd0, exp_nolast});
        check_val({tag, ".err_timeout"}, {31'd0, err_timeout}, {31'd0, exp_timeout});
    endtask

    task automatic check_ops(input string tag);
        for (int k = 0; k < 8; k++) begin
            check_val($sformatf("%s.i%0d", tag, k + 1), ops_o[k], exp_ops[k]);
        end
    endtask

    // Present one beat at a negedge, wait for it to be taken at the next posedge.
    task automatic send_beat(input int idx, input logic [31:0] d, input logic last, input logic clr);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_val("beat_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_data = d; in_last = last; err_clr = clr;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; err_clr = 1'b0; in_data = $urandom;
        exp_ops[idx] = d;
    endtask

    // Short frame of len<8 beats ending with in_last: discarded, err_short set.
    task automatic short_frame(input int len, input logic clr_same);
        for (int b = 0; b < len; b++) begin
            send_beat(b, $urandom, (b == len - 1), clr_same && (b == len - 1));
        end
        if (clr_same) begin
            exp_nolast = 1'b0; exp_timeout = 1'b0;
        end
        exp_short = 1'b1;
        check_val("short.start", {31'd0, start}, 32'd0);
        check_val("short.in_ready", {31'd0, in_ready}, 32'd1);
        check_val("short.busy", {31'd0, busy}, 32'd0);
        check_errs("short");
        check_ops("short");
    endtask

    // Full frame; start observed on the negedge after the 8th beat is taken.
    task automatic load_full(input logic [31:0] d [8], input logic nolast);
        for (int b = 0; b < 8; b++) begin
            send_beat(b, d[b], (b == 7) && !nolast, 1'b0);
        end
        if (nolast) exp_nolast = 1'b1;
        check_val("frame.start", {31'd0, start}, 32'd1);
        check_val("frame.busy", {31'd0, busy}, 32'd1);
        check_val("frame.in_ready", {31'd0, in_ready}, 32'd0);
        check_ops("frame");
        check_errs("frame");
    endtask

    // Run the datapath handshake; optionally complete the output transfer.
    task automatic run_frame(input logic [31:0] d [8], input logic nolast, input logic stale,
                             input int dly, input logic [31:0] res, input int rdly,
                             input logic handshake);
        load_full(d, nolast);
        done = stale; result_in = $urandom;
        @(negedge clk);
        check_val("wait.start_gone", {31'd0, start}, 32'd0);
        check_val("wait.stale_ignored", {31'd0, out_valid}, 32'd0);
        done = 1'b0;
        for (int k = 1; k < dly; k++) begin
            @(negedge clk);
            check_val("wait.no_out", {31'd0, out_valid}, 32'd0);
        end
        done = 1'b1; result_in = res;
        @(negedge clk);
        done = 1'($urandom); result_in = $urandom;
        for (int r = 0; r <= rdly; r++) begin
            check_val("out.valid", {31'd0, out_valid}, 32'd1);
            check_val("out.data", out_data, res);
            check_val("out.in_ready", {31'd0, in_ready}, 32'd0);
            if (r < rdly) @(negedge clk);
        end
        check_ops("out");
        if (handshake) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check_val("hs.valid_low", {31'd0, out_valid}, 32'd0);
            check_val("hs.busy_low", {31'd0, busy}, 32'd0);
            check_val("hs.in_ready", {31'd0, in_ready}, 32'd1);
            check_errs("hs");
        end
    endtask

    // Asynchronous reset between edges; everything must clear without a clock.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check_val({tag, ".start"}, {31'd0, start}, 32'd0);
        check_val({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        check_val({tag, ".out_data"}, out_data, 32'd0);
        check_val({tag, ".in_ready"}, {31'd0, in_ready}, 32'd0);
        check_val({tag, ".busy"}, {31'd0, busy}, 32'd0);
        for (int k = 0; k < 8; k++) exp_ops[k] = 32'd0;
        exp_short = 1'b0; exp_nolast = 1'b0; exp_timeout = 1'b0;
        check_ops(tag);
        check_errs(tag);
        @(negedge clk);
        rst = 1'b0;
        done = 1'b0;
        #1;
        check_val({tag, ".in_ready_after"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] fr [8];
        rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0;
        done = 1'b0; result_in = 32'd0; out_ready = 1'b0; err_clr = 1'b0;
        for (int k = 0; k < 8; k++) exp_ops[k] = 32'd0;
        exp_short = 1'b0; exp_nolast = 1'b0; exp_timeout = 1'b0;
        #1;
        check_val("rst.in_ready", {31'd0, in_ready}, 32'd0);
        check_val("rst.start", {31'd0, start}, 32'd0);
        check_val("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst.out_data", out_data, 32'd0);
        check_ops("rst");
        check_errs("rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("idle.in_ready", {31'd0, in_ready}, 32'd1);

        // Basic frame 1..8, done after 5 cycles, result 0x24, then backpressure 10 cycles.
        for (int k = 0; k < 8; k++) fr[k] = 32'(k + 1);
        run_frame(fr, 1'b0, 1'b0, 5, 32'h24, 0, 1'b1);
        run_frame(fr, 1'b0, 1'b0, 5, 32'h24, 10, 1'b1);

        // Short frame A,B,C, then a normal frame, then clear.
        send_beat(0, 32'hA, 1'b0, 1'b0);
        send_beat(1, 32'hB, 1'b0, 1'b0);
        send_beat(2, 32'hC, 1'b1, 1'b0);
        exp_short = 1'b1;
        check_val("short3.i1", i1, 32'hA);
        check_val("short3.i2", i2, 32'hB);
        check_val("short3.start", {31'd0, start}, 32'd0);
        check_val("short3.in_ready", {31'd0, in_ready}, 32'd1);
        check_errs("short3");
        for (int k = 0; k < 8; k++) fr[k] = $urandom;
        run_frame(fr, 1'b0, 1'b0, 3, 32'h1234_5678, 1, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_short = 1'b0;
        check_errs("clr");

        // No in_last on beat 8; stale done held high through the start cycle.
        done = 1'b1;
        for (int k = 0; k < 8; k++) fr[k] = $urandom;
        run_frame(fr, 1'b1, 1'b1, 4, 32'hCAFE_F00D, 2, 1'b1);

        // Set and clear in the same cycle: the set wins.
        short_frame(2, 1'b1);

        // Timeout: done never asserted.
        done = 1'b0;
        for (int k = 0; k < 8; k++) fr[k] = $urandom;
        load_full(fr, 1'b0);
        for (int c = 1; c < TO; c++) begin
            @(negedge clk);
            check_val("to.pending", {31'd0, err_timeout}, 32'd0);
            check_val("to.no_out", {31'd0, out_valid}, 32'd0);
        end
        check_val("to.busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk);
        exp_timeout = 1'b1;
        check_errs("to");
        check_val("to.busy", {31'd0, busy}, 32'd0);
        check_val("to.in_ready", {31'd0, in_ready}, 32'd1);
        check_val("to.out_valid", {31'd0, out_valid}, 32'd0);

        // Done arriving on the last allowed cycle beats the timeout.
        for (int k = 0; k < 8; k++) fr[k] = $urandom;
        run_frame(fr, 1'b0, 1'b0, TO - 1, 32'h0BAD_0BAD, 0, 1'b1);

        // Reset mid-WAIT.
        for (int k = 0; k < 8; k++) fr[k] = $urandom;
        load_full(fr, 1'b0);
        @(negedge clk);
        @(negedge clk);
        async_reset("rst_wait");

        // Reset while OUT holds 0xDEADBEEF.
        for (int k = 0; k < 8; k++) fr[k] = $urandom;
        run_frame(fr, 1'b0, 1'b0, 2, 32'hDEAD_BEEF, 3, 1'b0);
        async_reset("rst_out");

        // Random traffic.
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                short_frame($urandom_range(1, 7), 1'($urandom));
            end
            if ($urandom_range(0, 4) == 0) begin
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
                exp_short = 1'b0; exp_nolast = 1'b0; exp_timeout = 1'b0;
                check_errs("rnd_clr");
            end
            for (int k = 0; k < 8; k++) fr[k] = $urandom;
            run_frame(fr, ($urandom_range(0, 3) == 0), 1'($urandom),
                      $urandom_range(1, 20), $urandom, $urandom_range(0, 5), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
